// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian WALK / flashing DON'T-WALK controller slaved to the
// vehicle light FSM, with request latching and illegal-light fault detection.
module ped_crossing_ctrl #(
    parameter int CNT_W     = 32,
    parameter int FLASH_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             greenlt,
    input  logic             yellowlt,
    input  logic             redlt,
    input  logic             ped_btn,
    input  logic [CNT_W-1:0] walk_cycles,
    input  logic [CNT_W-1:0] flash_cycles,
    output logic             walk,
    output logic             dont_walk,
    output logic             ped_wait,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WALK, S_FLASH, S_CLEAR, S_FAULT} state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d, redlt_q, btn_q, blink_q, blink_d, legal_q, legal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, countdown_q, countdown_d;
    logic [7:0]       div_q, div_d;
    logic             walk_q, walk_d, dont_walk_q, dont_walk_d, fault_q, fault_d;
    logic             press, red_rise, red_fall, legal, div_wrap;

    assign press    = ped_btn & ~btn_q;
    assign red_rise = redlt & ~redlt_q;
    assign red_fall = ~redlt & redlt_q;
    assign legal    = $onehot({greenlt, yellowlt, redlt});
    assign div_wrap = div_q == 8'(FLASH_DIV - 1);

    always_comb begin
        state_d = state_q;
        req_d   = req_q | (press & (state_q != S_FAULT));
        cnt_d   = cnt_q;
        blink_d = blink_q;
        div_d   = div_q;
        legal_d = legal_q;
        if (!legal) begin
            state_d = S_FAULT;
            req_d   = 1'b0;
            cnt_d   = '0;
            legal_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = req_d ? S_WAIT : S_IDLE;
                S_WAIT: if (red_rise) begin
                    req_d   = 1'b0;
                    cnt_d   = (walk_cycles == '0) ? CNT_W'(1) : walk_cycles;
                    state_d = S_WALK;
                end
                S_WALK: if (red_fall) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = (flash_cycles != '0) ? S_FLASH : S_CLEAR;
                    cnt_d   = flash_cycles;
                    blink_d = 1'b1;
                    div_d   = 8'd0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                S_FLASH: if (red_fall || cnt_q == CNT_W'(1)) begin
                    state_d = red_fall ? S_IDLE : S_CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
                    div_d   = div_wrap ? 8'd0 : div_q + 8'd1;
                    blink_d = div_wrap ? ~blink_q : blink_q;
                end
                S_CLEAR: state_d = redlt ? S_CLEAR : S_IDLE;
                S_FAULT: begin
                    // two consecutive legal non-red samples release the fault
                    req_d   = 1'b0;
                    legal_d = ~redlt;
                    state_d = (legal_q && !redlt) ? S_IDLE : S_FAULT;
                end
                default: state_d = S_IDLE;
            endcase
        end
        walk_d      = state_d == S_WALK;
        dont_walk_d = (state_d == S_WALK) ? 1'b0 : (state_d == S_FLASH) ? blink_d : 1'b1;
        countdown_d = (state_d == S_WALK || state_d == S_FLASH) ? cnt_d : '0;
        fault_d     = state_d == S_FAULT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            redlt_q     <= 1'b0;
            btn_q       <= 1'b0;
            cnt_q       <= '0;
            blink_q     <= 1'b1;
            div_q       <= 8'd0;
            legal_q     <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            countdown_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            redlt_q     <= redlt;
            btn_q       <= ped_btn;
            cnt_q       <= cnt_d;
            blink_q     <= blink_d;
            div_q       <= div_d;
            legal_q     <= legal_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            countdown_q <= countdown_d;
            fault_q     <= fault_d;
        end
    end

    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign ped_wait  = req_q;
    assign countdown = countdown_q;
    assign fault     = fault_q;
endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
Pedestrian signal controller that sits directly downstream of the traffic-light counter FSM and consumes its one-hot greenlt/yellowlt/redlt outputs. It latches pedestrian button requests and waits for the next vehicle-red phase. It then drives a timed WALK phase, a flashing DON'T-WALK clearance phase, and a solid DON'T-WALK hold until the vehicle red ends. It also detects illegal (non-one-hot) light combinations from the upstream FSM.

Parameters:
CNT_W, 32, width of the timing inputs and of the countdown output
FLASH_DIV, 2, number of clocks per dont_walk blink half-period in FLASH (legal range 1 to 255)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
greenlt  input  1  vehicle green from the traffic-light FSM
yellowlt  input  1  vehicle yellow from the traffic-light FSM
redlt  input  1  vehicle red from the traffic-light FSM
ped_btn  input  1  pedestrian button level, already synchronous to clk
walk_cycles  input  CNT_W  WALK duration in clocks; 0 is treated as 1
flash_cycles  input  CNT_W  flashing clearance duration in clocks; 0 skips FLASH
walk  output  1  WALK lamp
dont_walk  output  1  DON'T-WALK lamp (solid or blinking)
ped_wait  output  1  request pending (button acknowledged, not yet served)
countdown  output  CNT_W  clocks remaining in WALK or FLASH (including current); 0 otherwise
fault  output  1  illegal light combination seen; held while in FAULT

Behaviour:
- Reset (reset=0, async): state=IDLE, request latch=0, redlt_q=0, btn_q=0, cnt=0, blink phase=1.
- Outputs during reset: walk=0, dont_walk=1, ped_wait=0, countdown=0, fault=0.
- States: IDLE, WAIT, WALK, FLASH, CLEAR, FAULT. Outputs are decoded from registered state and counters, so there is no combinational path from inputs to outputs.
- Button press = ped_btn & ~btn_q (rising edge). A press sets the request latch in any state except FAULT. A held button counts once.
- ped_wait = request latch.
- Red rise = redlt & ~redlt_q. Red fall = ~redlt & redlt_q.
- Legal lights: exactly one of greenlt, yellowlt, redlt is high. Any illegal sample moves the FSM to FAULT on that edge, from every state. Highest priority.
- IDLE: walk=0, dont_walk=1. Moves to WAIT when the request latch is set or a press occurs this cycle.
- WAIT: walk=0, dont_walk=1. On red rise it clears the request latch, loads cnt=max(walk_cycles,1), and moves to WALK.
  - A request present while red is already high waits for the next red rise; a partial red window is never used.
- WALK: walk=1, dont_walk=0, countdown=cnt, cnt decrements each clock.
  - When cnt==1: if flash_cycles!=0, load cnt=flash_cycles, set blink phase=1, and go to FLASH; else go to CLEAR.
- FLASH: walk=0, dont_walk=blink phase, countdown=cnt.
  - blink phase inverts every FLASH_DIV clocks. The first FLASH_DIV clocks show 1.
  - When cnt==1, go to CLEAR.
- Abort: a red fall while in WALK or FLASH forces IDLE on that edge (dont_walk=1, countdown=0). A pending latch re-enters WAIT the next cycle.
- CLEAR: walk=0, dont_walk=1. Goes to IDLE when redlt=0; a red fall is not required.
- Presses during WALK, FLASH or CLEAR set the latch and are served on the next red rise.
- FAULT: walk=0, dont_walk=1, fault=1, countdown=0, request latch cleared.
  - Exit to IDLE only after 2 consecutive legal samples with redlt=0.
- countdown=0 in IDLE, WAIT, CLEAR and FAULT.
- Counters never underflow: cnt is only decremented while ≥1.
- Walk-start latency: walk rises on the first clk edge at which redlt=1 and redlt_q=0, i.e. one clock after the upstream FSM asserts red.
- Simultaneous press and red rise while in IDLE: the state goes to WAIT only. That red phase is not served.

Test Plan:
- Reset: hold reset=0 with random inputs → walk=0, dont_walk=1, ped_wait=0, countdown=0, fault=0; outputs asynchronous to clk.
- Nominal, upstream green=4/yellow=2/red=4: press during green → ped_wait=1; at red rise, walk=1 for 2 clocks (walk_cycles=2, countdown 2,1). Then FLASH for 1 clock (flash_cycles=1, dont_walk=1, countdown=1). Then CLEAR until red drops, then IDLE; ped_wait=0 from WALK entry.
- Abort: walk_cycles=5, red=4 → red fall during WALK returns to IDLE on the same edge, walk=0, countdown=0. A press during WALK re-enters WAIT and is served on the next red rise.
- Flash pattern: FLASH_DIV=2, flash_cycles=6, long red → dont_walk 1,1,0,0,1,1, then solid 1 in CLEAR; walk_cycles=0 gives exactly 1 WALK clock; flash_cycles=0 goes WALK→CLEAR directly.
- Late request: press while redlt=1 and no request pending → no WALK in that red; WALK starts at the next red rise.
- Fault: force greenlt=1 and redlt=1 for 1 clock during WALK → FAULT, fault=1, walk=0, latch cleared. Then 2 legal samples with red=0 → IDLE, fault=0.
